fetch_queue_cu: RTL and testbench
=================================

FETCH_QUEUE_CU -- requirements
Module: fetch_queue_cu

Interface
REQ-001 SHALL have parameter FETCH_BYTES, default 4: bytes returned per instruction-memory read (1, 2 or 4).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 16: byte-queue capacity (power of 2, >= 8).
REQ-003 SHALL have parameter RESET_PC, default 32'h0: fetch address after reset.
REQ-004 SHALL have parameter RESET_MODE, default 1'b0: ISA mode after reset.
REQ-005 SHALL have ports:
  clk  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-high
  instmem_addr  out  32  byte address of current read
  instmem_rd  out  1  read issued this cycle
  instmem_dataout  in  8*FETCH_BYTES  bytes at addr..addr+FETCH_BYTES-1, little-endian, same cycle
  m_do_jmp / d_do_jmp / t_do_jmp  in  1 each  redirect requests
  m_/d_/t_target_pc  in  32 each  redirect targets
  m_/d_/t_target_mode  in  1 each  redirect modes
  inst_valid  out  1  inst holds a complete instruction
  inst_ready  in  1  decode accepts
  inst  out  48  instruction bytes, byte 0 in [7:0], unused bytes zero
  inst_pc  out  32  address of inst byte 0
  next_inst_pc  out  32  inst_pc + instruction length
  inst_mode  out  1  current mode
  queue_count  out  $clog2(QUEUE_DEPTH)+1  bytes held

Function
REQ-006 SHALL hold fetched bytes in a circular queue with head/tail pointers wrapping modulo QUEUE_DEPTH.
REQ-007 SHALL assert instmem_rd, with instmem_addr = fetch_pc, iff QUEUE_DEPTH - queue_count >= FETCH_BYTES and no redirect this cycle; on read, push all FETCH_BYTES bytes and advance fetch_pc by FETCH_BYTES (32-bit wrap).
REQ-008 Instruction length SHALL be 4 in mode 0; in mode 1 it is table[head_byte[3:0]], table 0..F = 1,1,2,6,6,6,2,5,2,5,1,2,2,1,1,1.
REQ-009 inst_valid SHALL be high iff available bytes >= length and no redirect this cycle.
REQ-010 On inst_valid && inst_ready, SHALL pop length bytes and set inst_pc <= next_inst_pc at the next edge.
REQ-011 With inst_valid && !inst_ready, inst, inst_pc, next_inst_pc SHALL hold stable; prefetch continues until full.
REQ-012 Redirect priority SHALL be m > d > t; the winner flushes the queue (count 0) and sets fetch_pc, inst_pc <= target_pc, inst_mode <= target_mode at the next edge; pop and push in that cycle are discarded.
REQ-013 Simultaneous push and pop SHALL give count = count + FETCH_BYTES - length; queue never overflows or underflows.
REQ-014 inst_mode SHALL change only via redirect or reset.

Reset
REQ-015 While reset is high: queue_count = 0, head = tail = 0, fetch_pc = inst_pc = RESET_PC, inst_mode = RESET_MODE, inst_valid = 0, instmem_rd = 0, inst = 0.
REQ-016 Reset mid-instruction SHALL discard partial bytes; first read after release is at RESET_PC.

Configuration
REQ-017 Macro FETCH_BYPASS_EN defined: bytes arriving on instmem_dataout SHALL count toward REQ-009 same cycle (zero-latency from memory to inst_valid).
REQ-018 Macro FETCH_BYPASS_EN undefined: inst_valid and inst SHALL depend on registered queue contents only (one extra cycle after a read).

Verification
REQ-019 Reset release, mode 0, FETCH_BYTES=4, memory 0x00..: bypass on -> inst_valid cycle 1, inst_pc=0, next_inst_pc=4; bypass off -> cycle 2.
REQ-020 Mode 1, bytes 03,xx*5,01,07: pops give lengths 6,1,5 with inst_pc 0,6,7.
REQ-021 inst_ready=0 for 20 cycles -> queue_count saturates at 16, instmem_rd=0, inst stable.
REQ-022 m_do_jmp (0x100, mode 1) and d_do_jmp (0x200) same cycle -> inst_valid=0 that cycle, next reads at 0x100, inst_mode=1.
REQ-023 FETCH_BYTES=1, mode 1 6-byte instruction near tail pointer wrap -> inst bytes correct across wrap.
REQ-024 Reset asserted with queue_count=5 -> outputs per REQ-015 immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_queue_cu.sv
// ---------------------------------------------------------------------------
// fetch_queue_cu -- instruction fetch byte queue and control unit
//
// Prefetches FETCH_BYTES bytes per cycle from instruction memory into a
// circular byte queue and presents one complete instruction at a time to
// decode. Instruction length is 4 bytes in mode 0; in mode 1 it is looked
// up from the low nibble of the first instruction byte. Redirect requests
// (priority m > d > t) flush the queue and restart fetch at the target.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : bytes returned by memory this cycle count toward inst_valid
//               and feed inst directly (zero-latency memory -> decode).
//   undefined : inst_valid / inst depend on registered queue contents only.
//
// Ports
//   clk, reset (async, active-high)
//   instmem_addr / instmem_rd / instmem_dataout : memory read port,
//       data returned combinationally in the same cycle, little-endian
//   {m,d,t}_do_jmp / _target_pc / _target_mode   : redirect requests
//   inst_valid / inst_ready                      : decode handshake
//   inst, inst_pc, next_inst_pc, inst_mode       : presented instruction
//   queue_count                                  : bytes held in the queue
//
// Handshake: an instruction transfers on a rising edge where
// inst_valid && inst_ready. inst_valid never depends on inst_ready, and
// inst / inst_pc / next_inst_pc stay stable while inst_valid is high and
// inst_ready is low.
// ---------------------------------------------------------------------------
module fetch_queue_cu #(
    parameter int          FETCH_BYTES = 4,
    parameter int          QUEUE_DEPTH = 16,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic        RESET_MODE  = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [31:0]                    instmem_addr,
    output logic                           instmem_rd,
    input  logic [8*FETCH_BYTES-1:0]       instmem_dataout,
    input  logic                           m_do_jmp,
    input  logic                           d_do_jmp,
    input  logic                           t_do_jmp,
    input  logic [31:0]                    m_target_pc,
    input  logic [31:0]                    d_target_pc,
    input  logic [31:0]                    t_target_pc,
    input  logic                           m_target_mode,
    input  logic                           d_target_mode,
    input  logic                           t_target_mode,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [47:0]                    inst,
    output logic [31:0]                    inst_pc,
    output logic [31:0]                    next_inst_pc,
    output logic                           inst_mode,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int PW      = $clog2(QUEUE_DEPTH);
    localparam int CW      = PW + 1;
    localparam int MAX_LEN = 6;

    // Mode-1 instruction length, indexed by the low nibble of byte 0.
    function automatic int mode1_len(input logic [3:0] nib);
        case (nib)
            4'h0, 4'h1, 4'hA, 4'hD, 4'hE, 4'hF: mode1_len = 1;
            4'h2, 4'h6, 4'h8, 4'hB, 4'hC:       mode1_len = 2;
            4'h7, 4'h9:                         mode1_len = 5;
            default:                            mode1_len = 6; // 3, 4, 5
        endcase
    endfunction

    // State
    logic [7:0]    mem_q [QUEUE_DEPTH];
    logic [7:0]    mem_d [QUEUE_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inst_pc_q, inst_pc_d;
    logic          inst_mode_q, inst_mode_d;

    // Combinational intermediates
    logic          redirect;
    logic          rd;
    logic          valid;
    int            avail;
    int            len;
    int            push_len;
    int            pop_len;
    logic [7:0]    win [MAX_LEN];
    logic [47:0]   inst_w;
    logic [31:0]   next_pc_w;

    always_comb begin
        redirect = m_do_jmp | d_do_jmp | t_do_jmp;

        // A read is only issued when every returned byte has room to land.
        rd = !reset && !redirect &&
             ((QUEUE_DEPTH - int'(count_q)) >= FETCH_BYTES);

        avail = int'(count_q);
`ifdef FETCH_BYPASS_EN
        if (rd) begin
            avail = avail + FETCH_BYTES;
        end
`endif

        // Instruction window: queued bytes first, then (with bypass) the
        // bytes arriving from memory this cycle, which land right after them.
        for (int i = 0; i < MAX_LEN; i++) begin
            win[i] = 8'h00;
            if (i < int'(count_q)) begin
                win[i] = mem_q[PW'(int'(head_q) + i)];
            end
`ifdef FETCH_BYPASS_EN
            else if (rd && ((i - int'(count_q)) < FETCH_BYTES)) begin
                win[i] = instmem_dataout[(i - int'(count_q))*8 +: 8];
            end
`endif
        end

        len   = inst_mode_q ? mode1_len(win[0][3:0]) : 4;
        valid = !reset && !redirect && (avail >= len);

        inst_w = 48'h0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (valid && (i < len)) begin
                inst_w[i*8 +: 8] = win[i];
            end
        end
        next_pc_w = inst_pc_q + 32'(len);

        push_len = rd ? FETCH_BYTES : 0;
        pop_len  = (valid && inst_ready) ? len : 0;

        // Next-state defaults: push and pop applied together.
        mem_d = mem_q;
        if (rd) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                mem_d[PW'(int'(tail_q) + i)] = instmem_dataout[i*8 +: 8];
            end
        end
        head_d      = PW'(int'(head_q) + pop_len);
        tail_d      = PW'(int'(tail_q) + push_len);
        count_d     = CW'(int'(count_q) + push_len - pop_len);
        fetch_pc_d  = rd ? (fetch_pc_q + 32'(FETCH_BYTES)) : fetch_pc_q;
        inst_pc_d   = (pop_len != 0) ? next_pc_w : inst_pc_q;
        inst_mode_d = inst_mode_q;

        // Redirect wins over everything else in the cycle; rd and valid are
        // already forced low, so no push or pop happens either.
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (m_do_jmp) begin
                fetch_pc_d  = m_target_pc;
                inst_pc_d   = m_target_pc;
                inst_mode_d = m_target_mode;
            end else if (d_do_jmp) begin
                fetch_pc_d  = d_target_pc;
                inst_pc_d   = d_target_pc;
                inst_mode_d = d_target_mode;
            end else begin
                fetch_pc_d  = t_target_pc;
                inst_pc_d   = t_target_pc;
                inst_mode_d = t_target_mode;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q       <= '{default: 8'h00};
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            fetch_pc_q  <= RESET_PC;
            inst_pc_q   <= RESET_PC;
            inst_mode_q <= RESET_MODE;
        end else begin
            mem_q       <= mem_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            inst_pc_q   <= inst_pc_d;
            inst_mode_q <= inst_mode_d;
        end
    end

    assign instmem_addr = fetch_pc_q;
    assign instmem_rd   = rd;
    assign inst_valid   = valid;
    assign inst         = inst_w;
    assign inst_pc      = inst_pc_q;
    assign next_inst_pc = next_pc_w;
    assign inst_mode    = inst_mode_q;
    assign queue_count  = count_q;

endmodule

// File: tb/tb_fetch_queue_cu.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_cu -- self-checking bench for fetch_queue_cu (default
// parameters: FETCH_BYTES=4, QUEUE_DEPTH=16, RESET_PC=0, RESET_MODE=0).
//
// The reference model tracks the instruction stream as program order over a
// memory image: the presented instruction sits at mdl_pc, its bytes and
// length come straight from the image, and the queue holds exactly the bytes
// between mdl_pc and the fetch address mdl_fetch.
// ---------------------------------------------------------------------------
module tb_fetch_queue_cu;

    localparam int FB = 4;
    localparam int QD = 16;
    localparam int CW = 5;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT signals
    logic [31:0]      instmem_addr;
    logic             instmem_rd;
    logic [8*FB-1:0]  instmem_dataout;
    logic             m_do_jmp, d_do_jmp, t_do_jmp;
    logic [31:0]      m_target_pc, d_target_pc, t_target_pc;
    logic             m_target_mode, d_target_mode, t_target_mode;
    logic             inst_valid;
    logic             inst_ready;
    logic [47:0]      inst;
    logic [31:0]      inst_pc;
    logic [31:0]      next_inst_pc;
    logic             inst_mode;
    logic [CW-1:0]    queue_count;

    fetch_queue_cu #(
        .FETCH_BYTES (FB),
        .QUEUE_DEPTH (QD),
        .RESET_PC    (32'h0),
        .RESET_MODE  (1'b0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instmem_addr    (instmem_addr),
        .instmem_rd      (instmem_rd),
        .instmem_dataout (instmem_dataout),
        .m_do_jmp        (m_do_jmp),
        .d_do_jmp        (d_do_jmp),
        .t_do_jmp        (t_do_jmp),
        .m_target_pc     (m_target_pc),
        .d_target_pc     (d_target_pc),
        .t_target_pc     (t_target_pc),
        .m_target_mode   (m_target_mode),
        .d_target_mode   (d_target_mode),
        .t_target_mode   (t_target_mode),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .next_inst_pc    (next_inst_pc),
        .inst_mode       (inst_mode),
        .queue_count     (queue_count)
    );

    // Memory image, 1 KiB aliased over the whole address space.
    logic [7:0] mem_img [1024];

    always_comb begin
        instmem_dataout = '0;
        for (int i = 0; i < FB; i++) begin
            instmem_dataout[i*8 +: 8] = mem_img[10'(instmem_addr + 32'(i))];
        end
    end

    // Scoreboard state
    int          checks;
    int          failures;
    int          len_tbl [16] = '{1, 1, 2, 6, 6, 6, 2, 5, 2, 5, 1, 2, 2, 1, 1, 1};
    logic [31:0] mdl_pc;
    logic [31:0] mdl_fetch;
    logic        mdl_mode;
    logic [31:0] acc_pc  [$];
    int          acc_len [$];

    function automatic int exp_len(input logic [31:0] pc, input logic mode);
        logic [7:0] b0;
        b0 = mem_img[10'(pc)];
        return mode ? len_tbl[b0[3:0]] : 4;
    endfunction

    function automatic logic [47:0] exp_inst(input logic [31:0] pc, input logic mode);
        logic [47:0] r;
        int          l;
        r = '0;
        l = exp_len(pc, mode);
        for (int i = 0; i < l; i++) begin
            r[i*8 +: 8] = mem_img[10'(pc + 32'(i))];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_count"}, 64'(queue_count), 64'd0);
        chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_rd"},    64'(instmem_rd), 64'd0);
        chk({tag, "_inst"},  64'(inst), 64'd0);
        chk({tag, "_pc"},    64'(inst_pc), 64'd0);
        chk({tag, "_mode"},  64'(inst_mode), 64'd0);
        chk({tag, "_addr"},  64'(instmem_addr), 64'd0);
    endtask

    task automatic clear_jumps();
        m_do_jmp = 1'b0;
        d_do_jmp = 1'b0;
        t_do_jmp = 1'b0;
    endtask

    // One clock cycle: called just after a falling edge with inputs driven.
    // Checks all outputs against the model, then advances the model on the
    // rising edge and returns at the following falling edge.
    task automatic cycle();
        int   cnt, l, avail;
        logic e_rd, e_val, red, acc;
        #1;
        cnt   = int'(mdl_fetch - mdl_pc);
        red   = m_do_jmp | d_do_jmp | t_do_jmp;
        e_rd  = !red && ((QD - cnt) >= FB);
        avail = cnt + ((BYP && e_rd) ? FB : 0);
        l     = exp_len(mdl_pc, mdl_mode);
        e_val = !red && (avail >= l);
        acc   = e_val && inst_ready;

        chk("rd", 64'(instmem_rd), 64'(e_rd));
        if (e_rd) chk("addr", 64'(instmem_addr), 64'(mdl_fetch));
        chk("count", 64'(queue_count), 64'(cnt));
        chk("inst_pc", 64'(inst_pc), 64'(mdl_pc));
        chk("mode", 64'(inst_mode), 64'(mdl_mode));
        chk("valid", 64'(inst_valid), 64'(e_val));
        if (e_val) begin
            chk("inst", 64'(inst), 64'(exp_inst(mdl_pc, mdl_mode)));
            chk("next_pc", 64'(next_inst_pc), 64'(mdl_pc + 32'(l)));
        end
        if (inst_valid && inst_ready) begin
            acc_pc.push_back(inst_pc);
            acc_len.push_back(int'(next_inst_pc - inst_pc));
        end

        @(posedge clk);
        if (m_do_jmp) begin
            mdl_pc = m_target_pc; mdl_fetch = m_target_pc; mdl_mode = m_target_mode;
        end else if (d_do_jmp) begin
            mdl_pc = d_target_pc; mdl_fetch = d_target_pc; mdl_mode = d_target_mode;
        end else if (t_do_jmp) begin
            mdl_pc = t_target_pc; mdl_fetch = t_target_pc; mdl_mode = t_target_mode;
        end else begin
            if (e_rd) mdl_fetch = mdl_fetch + 32'(FB);
            if (acc)  mdl_pc = mdl_pc + 32'(l);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        inst_ready = 1'b0;
        clear_jumps();
        m_target_pc = '0; d_target_pc = '0; t_target_pc = '0;
        m_target_mode = 1'b0; d_target_mode = 1'b0; t_target_mode = 1'b0;

        for (int i = 0; i < 1024; i++) mem_img[i] = 8'($urandom_range(0, 255));
        mem_img[0] = 8'h10; mem_img[1] = 8'h20; mem_img[2] = 8'h30; mem_img[3] = 8'h40;
        // Mode-1 sequence of lengths 6, 1, 5 at 0x100.
        mem_img[10'h100] = 8'h03;
        mem_img[10'h106] = 8'h01;
        mem_img[10'h107] = 8'h07;
        // Three 6-byte instructions; the third straddles the queue wrap.
        mem_img[10'h180] = 8'h03;
        mem_img[10'h186] = 8'h04;
        mem_img[10'h18C] = 8'h05;

        mdl_pc = 32'h0; mdl_fetch = 32'h0; mdl_mode = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1 rst_chk("reset");

        // First read after release and inst_valid latency
        reset = 1'b0;
        #1;
        chk("first_rd", 64'(instmem_rd), 64'd1);
        chk("first_valid", 64'(inst_valid), 64'(BYP));
        cycle();
        #1;
        chk("second_valid", 64'(inst_valid), 64'd1);
        chk("second_pc", 64'(inst_pc), 64'd0);
        chk("second_next", 64'(next_inst_pc), 64'd4);

        // Decode stalled: queue fills, reads stop, instruction stays put
        repeat (20) cycle();
        #1;
        chk("stall_count", 64'(queue_count), 64'd16);
        chk("stall_rd", 64'(instmem_rd), 64'd0);
        chk("stall_valid", 64'(inst_valid), 64'd1);
        chk("stall_inst", 64'(inst), 64'h40302010);

        // Simultaneous m and d redirects: m wins
        acc_pc.delete(); acc_len.delete();
        m_do_jmp = 1'b1; m_target_pc = 32'h100; m_target_mode = 1'b1;
        d_do_jmp = 1'b1; d_target_pc = 32'h200; d_target_mode = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("jmp_valid", 64'(inst_valid), 64'd0);
        chk("jmp_rd", 64'(instmem_rd), 64'd0);
        cycle();
        clear_jumps();
        #1;
        chk("jmp_addr", 64'(instmem_addr), 64'h100);
        chk("jmp_mode", 64'(inst_mode), 64'd1);
        chk("jmp_count", 64'(queue_count), 64'd0);
        repeat (8) cycle();
        chk("m1_pc0", 64'(acc_pc[0]), 64'h100);
        chk("m1_len0", 64'(acc_len[0]), 64'd6);
        chk("m1_pc1", 64'(acc_pc[1]), 64'h106);
        chk("m1_len1", 64'(acc_len[1]), 64'd1);
        chk("m1_pc2", 64'(acc_pc[2]), 64'h107);
        chk("m1_len2", 64'(acc_len[2]), 64'd5);

        // 6-byte instruction across the queue pointer wrap (t-only redirect)
        acc_pc.delete(); acc_len.delete();
        t_do_jmp = 1'b1; t_target_pc = 32'h180; t_target_mode = 1'b1;
        cycle();
        clear_jumps();
        repeat (12) cycle();
        chk("wrap_pc0", 64'(acc_pc[0]), 64'h180);
        chk("wrap_pc1", 64'(acc_pc[1]), 64'h186);
        chk("wrap_pc2", 64'(acc_pc[2]), 64'h18C);
        chk("wrap_len2", 64'(acc_len[2]), 64'd6);

        // Randomized traffic with occasional redirects
        for (int k = 0; k < 800; k++) begin
            inst_ready    = ($urandom_range(0, 9) < 7);
            m_do_jmp      = ($urandom_range(0, 99) == 0);
            d_do_jmp      = ($urandom_range(0, 99) == 0);
            t_do_jmp      = ($urandom_range(0, 99) == 0);
            m_target_pc   = 32'($urandom_range(0, 1023));
            d_target_pc   = 32'($urandom_range(0, 1023));
            t_target_pc   = 32'($urandom_range(0, 1023));
            m_target_mode = 1'($urandom_range(0, 1));
            d_target_mode = 1'($urandom_range(0, 1));
            t_target_mode = 1'($urandom_range(0, 1));
            cycle();
        end
        clear_jumps();

        // Asynchronous reset with a partly filled queue (aim for 5 bytes)
        for (int k = 0; k < 300; k++) begin
            if (queue_count == 5'd5) break;
            inst_ready = ($urandom_range(0, 1) == 1);
            cycle();
        end
        #2 reset = 1'b1;
        #1 rst_chk("async_rst");
        @(negedge clk);
        reset = 1'b0;
        mdl_pc = 32'h0; mdl_fetch = 32'h0; mdl_mode = 1'b0;
        #1;
        chk("rel_rd", 64'(instmem_rd), 64'd1);
        chk("rel_addr", 64'(instmem_addr), 64'd0);
        inst_ready = 1'b1;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
